sw_capture_debouncer: RTL

SW_CAPTURE_DEBOUNCER -- requirements
Module: sw_capture_debouncer

---
 rtl/sw_capture_debouncer.sv | 78 +++++++
 1 files changed

// File: rtl/sw_capture_debouncer.sv
// sw_capture_debouncer: synchronizes and debounces SW/BTN, captures SW_STABLE into DATA on a button press.
// Define SW_AUTO_CAPTURE_EN to also capture on every change of SW_STABLE.
module sw_capture_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK100MHZ,
  input  logic       RESET,
  input  logic [9:0] SW,
  input  logic       BTN,
  output logic [9:0] SW_STABLE,
  output logic [9:0] DATA,
  output logic       DATA_VALID,
  input  logic       DATA_READY,
  output logic       OVERRUN
);
  localparam logic [19:0] LOAD_AT = 20'(DEBOUNCE_CYCLES - 2);
  localparam logic [19:0] SAT     = 20'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t      state;
  logic [9:0]  sw_s1, sw_s2, sw_s3;
  logic [19:0] sw_cnt, btn_cnt;
  logic        btn_s1, btn_s2, btn_s3, btn_stable, btn_prev;
  logic        sw_diff, btn_diff, sw_load, btn_load, capture;
  assign sw_diff  = sw_s2 != sw_s3;
  assign btn_diff = btn_s2 != btn_s3;
  // Counter restarts on every change; the load fires once, when the run reaches DEBOUNCE_CYCLES samples.
  assign sw_load  = !sw_diff && sw_cnt == LOAD_AT;
  assign btn_load = !btn_diff && btn_cnt == LOAD_AT;
`ifdef SW_AUTO_CAPTURE_EN
  logic sw_evt;
  assign capture = (btn_stable & ~btn_prev) | sw_evt;
`else
  assign capture = btn_stable & ~btn_prev;
`endif
  always_ff @(posedge CLK100MHZ or posedge RESET)
    if (RESET) begin
      {sw_s3, sw_s2, sw_s1} <= '0;
      {btn_s3, btn_s2, btn_s1} <= '0;
      sw_cnt <= '0;
      btn_cnt <= '0;
      SW_STABLE <= '0;
      btn_stable <= 1'b0;
      btn_prev <= 1'b0;
`ifdef SW_AUTO_CAPTURE_EN
      sw_evt <= 1'b0;
`endif
    end else begin
      {sw_s3, sw_s2, sw_s1} <= {sw_s2, sw_s1, SW};
      {btn_s3, btn_s2, btn_s1} <= {btn_s2, btn_s1, BTN};
      sw_cnt <= sw_diff ? '0 : (sw_cnt == SAT ? sw_cnt : sw_cnt + 20'd1);
      btn_cnt <= btn_diff ? '0 : (btn_cnt == SAT ? btn_cnt : btn_cnt + 20'd1);
      if (sw_load) SW_STABLE <= sw_s2;
      if (btn_load) btn_stable <= btn_s2;
      btn_prev <= btn_stable;
`ifdef SW_AUTO_CAPTURE_EN
      sw_evt <= sw_load && sw_s2 != SW_STABLE;
`endif
    end
  always_ff @(posedge CLK100MHZ or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      DATA <= '0;
      DATA_VALID <= 1'b0;
      OVERRUN <= 1'b0;
    end else if (state == IDLE) begin
      if (capture) begin
        DATA <= SW_STABLE;
        DATA_VALID <= 1'b1;
        state <= HOLD;
      end
    end else if (DATA_READY) begin
      if (capture) DATA <= SW_STABLE;
      else begin
        DATA_VALID <= 1'b0;
        state <= IDLE;
      end
    end else if (capture) OVERRUN <= 1'b1;
endmodule
